// File: rtl/strobe_decoder_pkg.sv
// Shared types and constants for the strobe decoder: FSM state encoding and
// the width of the pulse-length down-counter.
package strobe_decoder_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // Counter reload value: a strobe of len cycles ends when the count hits 0.
    function automatic logic [CNT_W-1:0] load_value(input int unsigned len);
        return CNT_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable 8-bit down-counter that times each strobe; tc_o flags a count of 0.
module strobe_timer
    import strobe_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/strobe_decoder.sv
// Address decoder with registered active-low one-cold strobes: level decode,
// timed single pulse, and an optional sweep of all outputs (STROBE_DECODER_SCAN_EN).
module strobe_decoder
    import strobe_decoder_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int PULSE_LEN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   _E,
    input  logic                   mode,
    input  logic                   start,
    input  logic                   scan,
    input  logic [ADDR_W-1:0]      A,
    output logic [2**ADDR_W-1:0]   _Y,
    output logic                   busy,
    output logic                   done
);

    localparam int N = 2**ADDR_W;
    localparam logic [CNT_W-1:0] LOAD_VAL = load_value(PULSE_LEN);

    state_e        state_q;
    logic [N-1:0]  y_q;
    logic          busy_q;
    logic          done_q;

    logic [N-1:0]  sel_cold_s;
    logic          start_go_s;
    logic          tmr_load_s;
    logic          tmr_dec_s;
    logic          tmr_tc_s;

`ifdef STROBE_DECODER_SCAN_EN
    logic [ADDR_W-1:0] scan_idx_q;
    logic [N-1:0]      scan_next_cold_s;
    logic              scan_go_s;
    logic              scan_last_s;
`else
    logic              unused_scan_s;
    assign unused_scan_s = scan;
`endif

    // One-cold decode of the live address and, when scanning, the next index.
    always_comb begin
        sel_cold_s = ~(N'(1) << A);
        start_go_s = mode & ~_E & start;
`ifdef STROBE_DECODER_SCAN_EN
        scan_next_cold_s = ~(N'(1) << (scan_idx_q + ADDR_W'(1)));
        scan_go_s        = mode & ~_E & ~start & scan;
        scan_last_s      = (scan_idx_q == ADDR_W'(N - 1));
`endif
    end

    // Timer control: load on entry (and per scan step), count down while active.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef STROBE_DECODER_SCAN_EN
                tmr_load_s = start_go_s | scan_go_s;
`else
                tmr_load_s = start_go_s;
`endif
            end
            STROBE: begin
                tmr_dec_s = ~_E;
            end
`ifdef STROBE_DECODER_SCAN_EN
            SCAN: begin
                if (!_E && tmr_tc_s && !scan_last_s) begin
                    tmr_load_s = 1'b1;
                end else begin
                    tmr_dec_s = ~_E;
                end
            end
`endif
            default: begin
                tmr_load_s = 1'b0;
                tmr_dec_s  = 1'b0;
            end
        endcase
    end

    strobe_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load_s),
        .dec_i      (tmr_dec_s),
        .load_val_i (LOAD_VAL),
        .tc_o       (tmr_tc_s)
    );

    // Control FSM with registered strobe, busy and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= {N{1'b1}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef STROBE_DECODER_SCAN_EN
            scan_idx_q <= {ADDR_W{1'b0}};
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!mode) begin
                        y_q <= _E ? {N{1'b1}} : sel_cold_s;
                    end else if (start_go_s) begin
                        state_q <= STROBE;
                        y_q     <= sel_cold_s;
                        busy_q  <= 1'b1;
`ifdef STROBE_DECODER_SCAN_EN
                    end else if (scan_go_s) begin
                        state_q    <= SCAN;
                        y_q        <= ~N'(1);
                        busy_q     <= 1'b1;
                        scan_idx_q <= {ADDR_W{1'b0}};
`endif
                    end else begin
                        y_q <= {N{1'b1}};
                    end
                end
                STROBE: begin
                    if (_E || tmr_tc_s) begin
                        state_q <= IDLE;
                        y_q     <= {N{1'b1}};
                        busy_q  <= 1'b0;
                        done_q  <= ~_E;
                    end else begin
                        state_q <= STROBE;
                    end
                end
`ifdef STROBE_DECODER_SCAN_EN
                SCAN: begin
                    if (_E) begin
                        state_q    <= IDLE;
                        y_q        <= {N{1'b1}};
                        busy_q     <= 1'b0;
                        scan_idx_q <= {ADDR_W{1'b0}};
                    end else if (tmr_tc_s && scan_last_s) begin
                        state_q    <= IDLE;
                        y_q        <= {N{1'b1}};
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        scan_idx_q <= {ADDR_W{1'b0}};
                    end else if (tmr_tc_s) begin
                        scan_idx_q <= scan_idx_q + ADDR_W'(1);
                        y_q        <= scan_next_cold_s;
                    end else begin
                        state_q <= SCAN;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    y_q     <= {N{1'b1}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign _Y   = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_strobe_decoder.sv
// Scoreboard bench for strobe_decoder: two instances (PULSE_LEN 3 and 255) share
// stimulus; a plan-queue reference model predicts every cycle's outputs.
module tb_strobe_decoder;

    typedef struct packed {
        logic [3:0] y;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_n = 1'b1;
    logic       mode = 1'b0;
    logic       st = 1'b0;
    logic       sc = 1'b0;
    logic [1:0] a = 2'd0;

    logic [3:0] y0, y1;
    logic       busy0, busy1, done0, done1;

    exp_t plan [2][$];
    exp_t sb   [2][$];
    exp_t mon_exp;
    exp_t mon_got;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    strobe_decoder #(.ADDR_W(2), .PULSE_LEN(3)) dut0 (
        .clk(clk), .reset(rst), ._E(en_n), .mode(mode), .start(st),
        .scan(sc), .A(a), ._Y(y0), .busy(busy0), .done(done0)
    );

    strobe_decoder #(.ADDR_W(2), .PULSE_LEN(255)) dut1 (
        .clk(clk), .reset(rst), ._E(en_n), .mode(mode), .start(st),
        .scan(sc), .A(a), ._Y(y1), .busy(busy1), .done(done1)
    );

    // Reference: a busy decoder simply plays back a precomputed list of output words.
    function automatic exp_t model_step(input int k, input int plen);
        exp_t e;
        exp_t w;
        e = '0;
        e.y = 4'hF;
        if (rst) begin
            plan[k].delete();
        end else if (plan[k].size() != 0) begin
            if (en_n) plan[k].delete();
            else e = plan[k].pop_front();
        end else if (!mode) begin
            if (!en_n) e.y = ~(4'b0001 << a);
        end else if (!en_n && st) begin
            w.y = ~(4'b0001 << a); w.busy = 1'b1; w.done = 1'b0;
            for (int i = 0; i < plen; i++) plan[k].push_back(w);
            w.y = 4'hF; w.busy = 1'b0; w.done = 1'b1;
            plan[k].push_back(w);
            e = plan[k].pop_front();
        end
`ifdef STROBE_DECODER_SCAN_EN
        else if (!en_n && sc) begin
            for (int idx = 0; idx < 4; idx++) begin
                w.y = ~(4'b0001 << idx); w.busy = 1'b1; w.done = 1'b0;
                for (int i = 0; i < plen; i++) plan[k].push_back(w);
            end
            w.y = 4'hF; w.busy = 1'b0; w.done = 1'b1;
            plan[k].push_back(w);
            e = plan[k].pop_front();
        end
`endif
        return e;
    endfunction

    task automatic drive(input logic r, input logic e, input logic m,
                         input logic s0, input logic s1, input logic [1:0] ad);
        @(negedge clk);
        rst = r; en_n = e; mode = m; st = s0; sc = s1; a = ad;
        sb[0].push_back(model_step(0, 3));
        sb[1].push_back(model_step(1, 255));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    // Monitor: after each edge, compare each instance against its oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (sb[k].size() != 0) begin
                    mon_exp = sb[k].pop_front();
                    mon_got = (k == 0) ? {y0, busy0, done0} : {y1, busy1, done1};
                    n_vec++;
                    if (mon_got !== mon_exp) begin
                        n_err++;
                        $display("FAIL dut%0d t=%0t got _Y=%b busy=%b done=%b want _Y=%b busy=%b done=%b",
                                 k, $time, mon_got.y, mon_got.busy, mon_got.done,
                                 mon_exp.y, mon_exp.busy, mon_exp.done);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held two cycles
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        // Level decode, then disable
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'(i));
        // Pulse on A=1 with A moving to 3 while busy
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        // Abort in the second strobe cycle
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        // Scan request (start has priority when both are high)
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        idle(16);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
        idle(6);
        // Reset mid-pulse, then a full 255-cycle strobe
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        idle(100);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        idle(260);
        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)));
        end
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (sb[k].size() != 0) begin
                n_err++;
                $display("FAIL drain dut%0d got %0d pending want 0", k, sb[k].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
